// File: rtl/seg7_pkg.sv
// Shared seven-segment code set (active-low, bit 6 = g, bit 0 = a) used by the
// digit counters and the read-side monitor.
`default_nettype none

package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;

    function automatic logic [6:0] seg7_encode(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_OFF;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// Combinational decode of an active-low segment pattern into blank / BCD digit.
`default_nettype none

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_is_off,
    output logic       o_is_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_is_off   = (i_seg == SEG_OFF);
        o_is_digit = 1'b0;
        o_digit    = 4'd0;
        for (int d = 0; d < 10; d++) begin
            if (i_seg == seg7_encode(4'(d))) begin
                o_is_digit = 1'b1;
                o_digit    = 4'(d);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seg_digit_monitor.sv
// Read-side checker: decodes a HEX segment bus and verifies +1 (mod 10) stepping.
// Optional SEG_MONITOR_DEBOUNCE_EN requires two equal samples before evaluation.
`default_nettype none

module seg_digit_monitor
    import seg7_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         seg_in,
    input  logic               clear_err,
    output logic [3:0]         digit,
    output logic               digit_valid,
    output logic               blank,
    output logic               carry_pulse,
    output logic [COUNT_W-1:0] gen_count,
    output logic               code_err,
    output logic               seq_err
);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             r_state, w_state_nx;
    logic [6:0]         r_seg_q, r_acc_q;
    logic [3:0]         r_digit, w_digit_nx, w_digit_inc;
    logic [COUNT_W-1:0] r_gen, w_gen_nx;
    logic               r_valid, r_blank, r_carry, r_code_err, r_seq_err;
    logic               w_carry_nx, w_code_err_nx, w_seq_err_nx;
    logic               w_eval, w_is_off, w_is_digit;
    logic [3:0]         w_dec_digit;

`ifdef SEG_MONITOR_DEBOUNCE_EN
    logic [6:0] r_seg_qq;

    always_ff @(posedge clk) begin
        if (!reset) r_seg_qq <= SEG_OFF;
        else        r_seg_qq <= r_seg_q;
    end

    // A glitch never matches its neighbour sample, so it is never evaluated.
    assign w_eval = (r_seg_q == r_seg_qq) && (r_seg_q != r_acc_q);
`else
    assign w_eval = (r_seg_q != r_acc_q);
`endif

    seg7_decode u_decode (
        .i_seg      (r_seg_q),
        .o_is_off   (w_is_off),
        .o_is_digit (w_is_digit),
        .o_digit    (w_dec_digit)
    );

    assign w_digit_inc = (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;

    always_comb begin
        w_state_nx    = r_state;
        w_digit_nx    = r_digit;
        w_gen_nx      = r_gen;
        w_carry_nx    = 1'b0;
        w_code_err_nx = r_code_err & ~clear_err;
        w_seq_err_nx  = r_seq_err & ~clear_err;
        case (r_state)
            ST_BLANK: begin
                if (w_eval && !w_is_off) begin
                    if (!w_is_digit) begin
                        w_state_nx    = ST_FAULT;
                        w_code_err_nx = 1'b1;
                    end else if (w_dec_digit == 4'd0) begin
                        w_state_nx = ST_RUN;
                        w_digit_nx = 4'd0;
                        w_gen_nx   = '0;
                    end else begin
                        w_state_nx   = ST_FAULT;
                        w_seq_err_nx = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_eval) begin
                    if (w_is_digit && (w_dec_digit == w_digit_inc)) begin
                        w_digit_nx = w_dec_digit;
                        w_carry_nx = (r_digit == 4'd9);
                        if (r_gen != '1) w_gen_nx = r_gen + 1'b1;
                    end else if (w_is_off) begin
                        w_state_nx = ST_BLANK;
                        w_gen_nx   = '0;
                    end else if (w_is_digit) begin
                        w_state_nx   = ST_FAULT;
                        w_seq_err_nx = 1'b1;
                    end else begin
                        w_state_nx    = ST_FAULT;
                        w_code_err_nx = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (clear_err) begin
                    w_state_nx = ST_BLANK;
                    w_gen_nx   = '0;
                end
            end
            default: w_state_nx = ST_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_BLANK;
            r_seg_q    <= SEG_OFF;
            r_acc_q    <= SEG_OFF;
            r_digit    <= 4'd0;
            r_gen      <= '0;
            r_valid    <= 1'b0;
            r_blank    <= 1'b1;
            r_carry    <= 1'b0;
            r_code_err <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_seg_q    <= seg_in;
            if (w_eval) r_acc_q <= r_seg_q;
            r_digit    <= w_digit_nx;
            r_gen      <= w_gen_nx;
            r_valid    <= (w_state_nx == ST_RUN);
            r_blank    <= (w_state_nx == ST_BLANK);
            r_carry    <= w_carry_nx;
            r_code_err <= w_code_err_nx;
            r_seq_err  <= w_seq_err_nx;
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_valid;
    assign blank       = r_blank;
    assign carry_pulse = r_carry;
    assign gen_count   = r_gen;
    assign code_err    = r_code_err;
    assign seq_err     = r_seq_err;

endmodule

`default_nettype wire

// File: tb/tb_seg_digit_monitor.sv
// Directed bench for seg_digit_monitor; two instances (COUNT_W 8 and 4) share stimulus.
`default_nettype none

module tb_seg_digit_monitor;

`ifdef SEG_MONITOR_DEBOUNCE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       clear_err;

    logic [3:0] digit8, digit4;
    logic       valid8, valid4, blank8, blank4, carry8, carry4;
    logic       ce8, ce4, se8, se4;
    logic [7:0] gen8;
    logic [3:0] gen4;

    always #5 clk = ~clk;

    seg_digit_monitor #(.COUNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .seg_in(seg_in), .clear_err(clear_err),
        .digit(digit8), .digit_valid(valid8), .blank(blank8), .carry_pulse(carry8),
        .gen_count(gen8), .code_err(ce8), .seq_err(se8)
    );

    seg_digit_monitor #(.COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .seg_in(seg_in), .clear_err(clear_err),
        .digit(digit4), .digit_valid(valid4), .blank(blank4), .carry_pulse(carry4),
        .gen_count(gen4), .code_err(ce4), .seq_err(se4)
    );

    typedef struct {
        logic [6:0] seg;
        logic       clr;
        int         dig;
        int         val;
        int         blk;
        int         ce;
        int         se;
        int         g8;
        int         g4;
        int         nc;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] C[10];
    logic [6:0] OFF;
    logic [6:0] INV;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int dig, input int val, input int blk,
                           input int ce, input int se, input int g8, input int g4);
        chk({tag, "_digit"}, int'(digit8), dig);
        chk({tag, "_valid"}, int'(valid8), val);
        chk({tag, "_blank"}, int'(blank8), blk);
        chk({tag, "_code_err"}, int'(ce8), ce);
        chk({tag, "_seq_err"}, int'(se8), se);
        chk({tag, "_gen8"}, int'(gen8), g8);
        chk({tag, "_gen4"}, int'(gen4), g4);
        chk({tag, "_digit4"}, int'(digit4), dig);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void add(input logic [6:0] seg, input logic clr, input int dig,
                                input int val, input int blk, input int ce, input int se,
                                input int g8, input int g4, input int nc);
        vec_t v;
        v.seg = seg; v.clr = clr; v.dig = dig; v.val = val; v.blk = blk;
        v.ce = ce; v.se = se; v.g8 = g8; v.g4 = g4; v.nc = nc;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input int idx);
        int nc;
        int at;
        nc = 0;
        at = -1;
        seg_in    = v.seg;
        clear_err = v.clr;
        for (int c = 1; c <= 4; c++) begin
            tick(1);
            if (carry8) begin
                nc++;
                at = c;
            end
        end
        clear_err = 1'b0;
        chk_all($sformatf("v%0d", idx), v.dig, v.val, v.blk, v.ce, v.se, v.g8, v.g4);
        chk($sformatf("v%0d_carries", idx), nc, v.nc);
        if (v.nc == 1) chk($sformatf("v%0d_carry_edge", idx), at, LAT);
    endtask

    task automatic hold(input logic [6:0] seg);
        seg_in = seg;
        tick(4);
    endtask

    initial begin
        C[0] = 7'b1000000; C[1] = 7'b1111001; C[2] = 7'b0100100; C[3] = 7'b0110000;
        C[4] = 7'b0011001; C[5] = 7'b0010010; C[6] = 7'b0000010; C[7] = 7'b1111000;
        C[8] = 7'b0000000; C[9] = 7'b0010000;
        OFF = 7'b1111111;
        INV = 7'b1010101;

        reset     = 1'b0;
        seg_in    = OFF;
        clear_err = 1'b0;
        tick(2);
        chk_all("reset", 0, 0, 1, 0, 0, 0, 0);
        chk("reset_carry", int'(carry8), 0);
        reset = 1'b1;

        // Normal count off, 0..9, 0
        add(OFF, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(C[0], 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int d = 1; d < 10; d++) add(C[d], 0, d, 1, 0, 0, 0, d, d, 0);
        add(C[0], 0, 0, 1, 0, 0, 0, 10, 10, 1);
        // Invalid code, then clear to blank
        add(C[0], 0, 0, 1, 0, 0, 0, 10, 10, 0);
        add(INV, 0, 0, 0, 0, 1, 0, 10, 10, 0);
        add(OFF, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        // Skipped digit
        add(C[0], 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(C[1], 0, 1, 1, 0, 0, 0, 1, 1, 0);
        add(C[3], 0, 1, 0, 0, 0, 1, 1, 1, 0);
        add(OFF, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        // Return to blank from gen_count 5, then 20 steps for saturation
        for (int d = 0; d < 6; d++) add(C[d], 0, d, 1, 0, 0, 0, d, d, 0);
        add(OFF, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        add(C[0], 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++)
            add(C[k % 10], 0, k % 10, 1, 0, 0, 0, k, (k > 15) ? 15 : k, (k % 10 == 0) ? 1 : 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Illegal step evaluated in the same cycle as clear_err: error wins
        seg_in = C[5];
        tick(LAT - 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        tick(2);
        chk_all("err_vs_clear", 0, 0, 0, 0, 1, 20, 15);

        seg_in    = OFF;
        clear_err = 1'b1;
        tick(4);
        clear_err = 1'b0;
        chk_all("recover", 0, 0, 1, 0, 0, 0, 0);

        // One-cycle glitch between stable 3s
        for (int d = 0; d < 4; d++) hold(C[d]);
        chk_all("pre_glitch", 3, 1, 0, 0, 0, 3, 3);
        seg_in = C[9];
        tick(1);
        seg_in = C[3];
        tick(5);
`ifdef SEG_MONITOR_DEBOUNCE_EN
        chk_all("glitch", 3, 1, 0, 0, 0, 3, 3);
`else
        chk_all("glitch", 3, 0, 0, 0, 1, 3, 3);
`endif

        // Reset mid-operation
        reset = 1'b0;
        tick(1);
        chk_all("mid_reset", 0, 0, 1, 0, 0, 0, 0);
        seg_in = OFF;
        reset  = 1'b1;
        tick(3);
        chk_all("post_reset", 0, 0, 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_digit_monitor.md
# seg_digit_monitor

- Read-side checker for the seven-segment digit FSMs.
- Samples the active-low 7-bit segment bus that a digit counter drives onto a HEX display and decodes it back to a BCD digit.
- Verifies that each change is a legal +1 (mod 10) step from blank/zero, counts observed generations and flags illegal codes or skipped digits.
- Sits beside the ones-place counter on the game-of-life board as a self-check and as a digit source for logic that needs the numeric generation value.

## Interface

Parameters:
- COUNT_W, default 8: width of the saturating generation counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- seg_in  input  7  active-low segment pattern, bit 6 = segment g, bit 0 = segment a.
- clear_err  input  1  one-cycle request: clears error flags and leaves FAULT.
- digit  output  4  last accepted BCD digit, 0–9.
- digit_valid  output  1  high in RUN.
- blank  output  1  high in BLANK.
- carry_pulse  output  1  one-cycle pulse on an accepted 9→0 step.
- gen_count  output  COUNT_W  accepted +1 steps since leaving BLANK; saturates at all-ones.
- code_err  output  1  sticky: seg_in held a pattern that is neither blank nor a digit.
- seq_err  output  1  sticky: a legal digit arrived out of sequence.

## Operation

Codes, active-low:
- off = 1111111
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
- 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Any other pattern is invalid.

Pipeline: seg_in is registered into seg_q. The state machine acts only when seg_q differs from the last accepted code acc_q. acc_q resets to off.

**BLANK**
- off: stay.
- zero: go to RUN; digit=0, gen_count=0.
- Any other digit: go to FAULT; set seq_err.
- Invalid code: go to FAULT; set code_err.

**RUN**
- Code equal to (digit+1) mod 10: accept it and increment gen_count, saturating.
- 9→0 step: also pulse carry_pulse.
- off: go to BLANK; gen_count clears to 0.
- Any other digit, including a repeat after a glitch: go to FAULT; set seq_err.
- Invalid code: go to FAULT; set code_err.

**FAULT**
- digit_valid=0, blank=0.
- digit and gen_count hold their last values.
- seg_in is still tracked into acc_q but not checked.
- clear_err: go to BLANK.

Every change of seg_q updates acc_q, whether or not it is accepted.

Error flags:
- clear_err clears both flags in any state.
- An error detected in the same cycle as clear_err wins: the flag is set, the state goes to FAULT and clear_err is ignored.

## Timing

- All outputs are registered.
- Reset values: digit=0, digit_valid=0, blank=1, carry_pulse=0, gen_count=0, code_err=0, seq_err=0, state BLANK.
- Latency: a seg_in change at edge N is reflected on outputs after edge N+2 (sample stage plus state stage).
- carry_pulse is high for exactly that one cycle.
- A change every cycle is supported with no loss.
- Reset mid-operation returns to the reset values at the next edge and discards seg_q.

## Configuration

Macro SEG_MONITOR_DEBOUNCE_EN.

Defined:
- A new seg_q value must be stable for 2 consecutive samples before the state machine evaluates it.
- Single-cycle glitches are ignored with no error.
- Latency becomes 3 edges.

Undefined:
- Every sampled change is evaluated.
- A one-cycle glitch produces code_err or seq_err.

## Structure

- Shared package seg7_pkg holds the 11 segment code constants and a digit-to-code function. The digit counters use the same package.
- The state enum (BLANK, RUN, FAULT) is local to this block.
- One sub-module: seg7_decode, combinational, seg code → {is_off, is_digit, digit[3:0]}.
- Target size: about 150–250 lines total.

## Test plan

1. **Reset and normal count.** Hold reset=0 for 2 cycles, then drive off, 0, 1 … 9, 0, one value per 4 cycles.
   - After reset: blank=1, digit_valid=0.
   - At the end: digit=0, gen_count=10, one carry_pulse two edges after 0 is driven.
2. **Invalid code.** Drive 1000000, then 1010101.
   - code_err=1, state FAULT, digit_valid=0, digit holds 0.
   - Then clear_err plus off → blank=1, flags 0.
3. **Skipped digit.** Drive 0, 1, 3.
   - seq_err=1, digit holds 1, gen_count=1.
4. **Error and clear together.** Pulse clear_err in the same cycle the state machine evaluates an illegal step.
   - seq_err stays 1, state FAULT.
5. **Return to blank and saturation.** Drive off from RUN at gen_count=5 → blank=1, gen_count=0.
   - With COUNT_W=4, run 20 steps → gen_count=15.
6. **Debounce, both builds.** Drive a one-cycle 0010000 glitch between stable 3s.
   - With SEG_MONITOR_DEBOUNCE_EN defined: no error, digit=3.
   - Without it: seq_err=1.
